// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner
// Hunts for the MPEG-TS sync byte in a raw byte stream and locks once
// LOCK_CNT syncs in a row arrive exactly one packet length apart.
// While locked it forwards whole aligned packets, marking each packet
// start with o_Sync. It keeps flywheeling through isolated sync errors
// and drops lock only on a packet boundary.
module ts_sync_aligner #(
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic       i_Clk,
    input  logic       i_nRst,
    input  logic       i_Valid,
    input  logic [7:0] i_Data,
    input  logic [7:0] i_PacketLength,
    output logic       o_Valid,
    output logic       o_Sync,
    output logic [7:0] o_Data,
    output logic       o_Locked,
    output logic [7:0] o_SyncLossCnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      pos_q, pos_d;
    logic [GW-1:0]   good_q, good_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            valid_q, valid_d;
    logic            sync_q, sync_d;
    logic [7:0]      data_q, data_d;
    logic            locked_q, locked_d;
    logic [7:0]      lossCnt_q, lossCnt_d;

    logic [7:0]      posNext;
    logic [GW-1:0]   goodInc;
    logic [MW-1:0]   missInc;
    logic            isSync;
    logic            atBoundary;

    // Hunt/verify/lock decisions plus the forwarded byte for the next cycle
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        pos_d      = pos_q;
        good_d     = good_q;
        miss_d     = miss_q;
        valid_d    = 1'b0;
        sync_d     = 1'b0;
        data_d     = data_q;
        lossCnt_d  = lossCnt_q;

        posNext    = (pos_q == len_q - 8'd1) ? 8'd0 : pos_q + 8'd1;
        goodInc    = good_q + GW'(1);
        missInc    = miss_q + MW'(1);
        isSync     = (i_Data == SYNC_BYTE);
        atBoundary = (pos_q == 8'd0);

        if (i_Valid) begin
            case (state_q)
                HUNT: begin
                    if (isSync && (i_PacketLength >= 8'd8)) begin
                        len_d  = i_PacketLength;
                        pos_d  = 8'd1;
                        good_d = GW'(1);
                        miss_d = '0;
                        if (LOCK_CNT == 1) begin
                            state_d = LOCK;
                            valid_d = 1'b1;
                            sync_d  = 1'b1;
                            data_d  = i_Data;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    pos_d = posNext;
                    if (atBoundary) begin
                        if (isSync) begin
                            good_d = goodInc;
                            if (goodInc == GW'(LOCK_CNT)) begin
                                state_d = LOCK;
                                miss_d  = '0;
                                valid_d = 1'b1;
                                sync_d  = 1'b1;
                                data_d  = i_Data;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCK: begin
                    pos_d = posNext;
                    if (atBoundary && !isSync && (missInc == MW'(UNLOCK_CNT))) begin
                        state_d   = HUNT;
                        miss_d    = '0;
                        lossCnt_d = (lossCnt_q == 8'hFF) ? lossCnt_q : lossCnt_q + 8'd1;
                    end else begin
                        valid_d = 1'b1;
                        sync_d  = atBoundary;
                        data_d  = i_Data;
                        if (atBoundary) begin
                            miss_d = isSync ? '0 : missInc;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCK);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_q   <= HUNT;
            len_q     <= 8'd0;
            pos_q     <= 8'd0;
            good_q    <= '0;
            miss_q    <= '0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            data_q    <= 8'd0;
            locked_q  <= 1'b0;
            lossCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pos_q     <= pos_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            locked_q  <= locked_d;
            lossCnt_q <= lossCnt_d;
        end
    end

    assign o_Valid       = valid_q;
    assign o_Sync        = sync_q;
    assign o_Data        = data_q;
    assign o_Locked      = locked_q;
    assign o_SyncLossCnt = lossCnt_q;

endmodule
